// File: rtl/mmio_stream_hub.sv
// mmio_stream_hub: memory-mapped hub between the CPU load/store port and
// NUM_CH stream peripherals, with an RX and a TX FIFO per channel.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   cpu_ren/raddr/rdata   CPU read port, one-cycle latency; cpu_hit flags window hits
//   cpu_wen/waddr/wdata   CPU write port
//   rx_valid/data/ready   peripheral -> RX FIFO, one lane of DATA_W per channel
//   tx_valid/data/ready   TX FIFO -> peripheral, first-word-fall-through
//   irq                   registered level interrupt
//
// Window layout: addr[15:8] = BASE_ADDR[15:8], addr[7:2] = channel,
// addr[1:0] = register (0 DATA, 1 STATUS, 2 CTRL, 3 CLR).
module mmio_stream_hub #(
    parameter int          NUM_CH    = 2,
    parameter int          DATA_W    = 16,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_ren,
    input  logic [15:0]              cpu_raddr,
    output logic [15:0]              cpu_rdata,
    output logic                     cpu_hit,
    input  logic                     cpu_wen,
    input  logic [15:0]              cpu_waddr,
    input  logic [15:0]              cpu_wdata,
    input  logic [NUM_CH-1:0]        rx_valid,
    input  logic [NUM_CH*DATA_W-1:0] rx_data,
    output logic [NUM_CH-1:0]        rx_ready,
    output logic [NUM_CH-1:0]        tx_valid,
    output logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic [NUM_CH-1:0]        tx_ready,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic       r_win;
    logic       w_win;
    logic [5:0] r_ch;
    logic [5:0] w_ch;
    logic [1:0] r_reg;
    logic [1:0] w_reg;

    assign r_win = (cpu_raddr[15:8] == BASE_ADDR[15:8]);
    assign w_win = (cpu_waddr[15:8] == BASE_ADDR[15:8]);
    assign r_ch  = cpu_raddr[7:2];
    assign w_ch  = cpu_waddr[7:2];
    assign r_reg = cpu_raddr[1:0];
    assign w_reg = cpu_waddr[1:0];

    // Per-channel read-back word for the currently addressed register.
    logic [NUM_CH-1:0][15:0] rd_ch;
    logic [NUM_CH-1:0]       irq_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] rx_mem [DEPTH];
        logic [DATA_W-1:0] tx_mem [DEPTH];
        logic [AW-1:0]     rx_wp;
        logic [AW-1:0]     rx_rp;
        logic [AW-1:0]     tx_wp;
        logic [AW-1:0]     tx_rp;
        logic [CW-1:0]     rx_cnt;
        logic [CW-1:0]     tx_cnt;
        logic              rx_ovf;
        logic              tx_ovf;
        logic [1:0]        ctrl;

        logic rx_full;
        logic rx_empty;
        logic tx_full;
        logic tx_empty;
        logic rd_sel;
        logic wr_sel;
        logic rx_push;
        logic rx_pop;
        logic tx_wr;
        logic tx_push;
        logic tx_pop;
        logic clr_wr;
        logic ctrl_wr;
        logic [15:0] rd_val;

        assign rx_full  = (rx_cnt == FULL_CNT);
        assign rx_empty = (rx_cnt == '0);
        assign tx_full  = (tx_cnt == FULL_CNT);
        assign tx_empty = (tx_cnt == '0);

        assign rd_sel = cpu_ren & r_win & (r_ch == 6'(c));
        assign wr_sel = cpu_wen & w_win & (w_ch == 6'(c));

        // Full-ness is judged before any same-cycle pop, so a push into a
        // full FIFO is always dropped.
        assign rx_push = rx_valid[c] & ~rx_full;
        assign rx_pop  = rd_sel & (r_reg == 2'd0) & ~rx_empty;
        assign tx_wr   = wr_sel & (w_reg == 2'd0);
        assign tx_push = tx_wr & ~tx_full;
        assign tx_pop  = ~tx_empty & tx_ready[c];
        assign ctrl_wr = wr_sel & (w_reg == 2'd2);
        assign clr_wr  = wr_sel & (w_reg == 2'd3);

        always_ff @(posedge clk) begin
            if (rx_push) begin
                rx_mem[rx_wp] <= rx_data[c*DATA_W +: DATA_W];
            end
            if (tx_push) begin
                tx_mem[tx_wp] <= cpu_wdata[DATA_W-1:0];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_cnt <= '0;
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_cnt <= '0;
                rx_ovf <= 1'b0;
                tx_ovf <= 1'b0;
                ctrl   <= '0;
            end else begin
                if (rx_push) begin
                    rx_wp <= rx_wp + AW'(1);
                end
                if (rx_pop) begin
                    rx_rp <= rx_rp + AW'(1);
                end
                if (rx_push && !rx_pop) begin
                    rx_cnt <= rx_cnt + CW'(1);
                end else if (!rx_push && rx_pop) begin
                    rx_cnt <= rx_cnt - CW'(1);
                end

                if (tx_push) begin
                    tx_wp <= tx_wp + AW'(1);
                end
                if (tx_pop) begin
                    tx_rp <= tx_rp + AW'(1);
                end
                if (tx_push && !tx_pop) begin
                    tx_cnt <= tx_cnt + CW'(1);
                end else if (!tx_push && tx_pop) begin
                    tx_cnt <= tx_cnt - CW'(1);
                end

                // A new overflow outranks a clear in the same cycle.
                if (rx_valid[c] && rx_full) begin
                    rx_ovf <= 1'b1;
                end else if (clr_wr) begin
                    rx_ovf <= 1'b0;
                end
                if (tx_wr && tx_full) begin
                    tx_ovf <= 1'b1;
                end else if (clr_wr) begin
                    tx_ovf <= 1'b0;
                end

                if (ctrl_wr) begin
                    ctrl <= cpu_wdata[1:0];
                end
            end
        end

        always_comb begin
            rd_val = '0;
            case (r_reg)
                2'd0: rd_val = rx_empty ? 16'h0000 : 16'(rx_mem[rx_rp]);
                2'd1: rd_val = {8'(rx_cnt), 2'b00, tx_ovf, rx_ovf,
                                tx_full, tx_empty, rx_full, ~rx_empty};
                2'd2: rd_val = {14'h0000, ctrl};
                default: rd_val = {8'h00, 8'(tx_cnt)};
            endcase
        end

        assign rd_ch[c]  = rd_val;
        assign irq_ch[c] = (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);

        assign rx_ready[c] = ~rx_full;
        assign tx_valid[c] = ~tx_empty;
        assign tx_data[c*DATA_W +: DATA_W] = tx_mem[tx_rp];
    end

    // Channels beyond NUM_CH fall through to zero but still count as hits.
    logic [15:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 6'(i)) begin
                rd_mux = rd_ch[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            cpu_hit   <= cpu_ren & r_win;
            cpu_rdata <= (cpu_ren & r_win) ? rd_mux : 16'h0000;
            irq       <= |irq_ch;
        end
    end

endmodule

// File: tb/tb_mmio_stream_hub.sv
// tb_mmio_stream_hub: directed checks of mmio_stream_hub with
// NUM_CH=2, DATA_W=16, DEPTH=8, BASE_ADDR=16'hFF00.
module tb_mmio_stream_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ren;
    logic [15:0] cpu_raddr;
    logic [15:0] cpu_rdata;
    logic        cpu_hit;
    logic        cpu_wen;
    logic [15:0] cpu_waddr;
    logic [15:0] cpu_wdata;
    logic [1:0]  rx_valid;
    logic [31:0] rx_data;
    logic [1:0]  rx_ready;
    logic [1:0]  tx_valid;
    logic [31:0] tx_data;
    logic [1:0]  tx_ready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mmio_stream_hub #(
        .NUM_CH(2), .DATA_W(16), .DEPTH(8), .BASE_ADDR(16'hFF00)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
        .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .irq(irq)
    );

    task automatic rd(input logic [15:0] a, output logic [15:0] d,
                      output logic h);
        @(negedge clk);
        cpu_ren = 1'b1; cpu_raddr = a;
        @(negedge clk);
        cpu_ren = 1'b0; cpu_raddr = 16'h0000;
        d = cpu_rdata; h = cpu_hit;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        cpu_wen = 1'b1; cpu_waddr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_wen = 1'b0; cpu_waddr = 16'h0000; cpu_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        h;
        reset = 1'b1;
        cpu_ren = 0; cpu_raddr = 0; cpu_wen = 0; cpu_waddr = 0;
        cpu_wdata = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if ({tx_valid, rx_ready, irq, cpu_hit, cpu_rdata} !== {2'b00, 2'b11, 1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_outs: got tv=%b rr=%b irq=%b hit=%b rd=%h want tv=00 rr=11 irq=0 hit=0 rd=0000",
                     tx_valid, rx_ready, irq, cpu_hit, cpu_rdata);
        end
        reset = 1'b0;
        rd(16'hFF01, d, h);
        n_cmp++;
        if ({h, d} !== {1'b1, 16'h0004}) begin
            n_bad++;
            $display("FAIL reset_status: got hit=%b %h want hit=1 0004", h, d);
        end
        rd(16'h1234, d, h);
        n_cmp++;
        if ({h, d} !== {1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL miss_read: got hit=%b %h want hit=0 0000", h, d);
        end
    endtask

    task automatic test_rx_pop();
        logic [15:0] d;
        logic        h;
        @(negedge clk);
        rx_valid[0] = 1'b1; rx_data[15:0] = 16'h001C;
        @(negedge clk);
        rx_valid[0] = 1'b0;
        rd(16'hFF00, d, h);
        n_cmp++;
        if ({h, d} !== {1'b1, 16'h001C}) begin
            n_bad++;
            $display("FAIL rx_pop1: got hit=%b %h want hit=1 001c", h, d);
        end
        rd(16'hFF00, d, h);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL rx_pop_empty: got %h want 0000", d);
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_bad++;
            $display("FAIL rx_status_empty: got %h want 0004", d);
        end
    endtask

    task automatic test_rx_overflow();
        logic [15:0] d;
        logic        h;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            rx_valid[0] = 1'b1; rx_data[15:0] = 16'(i);
        end
        @(negedge clk);
        rx_valid[0] = 1'b0;
        n_cmp++;
        if (rx_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_ready_full: got %b want 0", rx_ready[0]);
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0817) begin
            n_bad++;
            $display("FAIL rx_status_full: got %h want 0817", d);
        end
        for (int i = 1; i <= 8; i++) begin
            rd(16'hFF00, d, h);
            n_cmp++;
            if (d !== 16'(i)) begin
                n_bad++;
                $display("FAIL rx_drain[%0d]: got %h want %h", i, d, 16'(i));
            end
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0014) begin
            n_bad++;
            $display("FAIL rx_ovf_sticky: got %h want 0014", d);
        end
        wr(16'hFF03, 16'h0000);
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_bad++;
            $display("FAIL rx_ovf_clr: got %h want 0004", d);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid[0] = 1'b1; rx_data[15:0] = 16'h0010 + 16'(i);
        end
        @(negedge clk);
        rx_data[15:0] = 16'h0099;
        cpu_wen = 1'b1; cpu_waddr = 16'hFF03; cpu_wdata = 16'hFFFF;
        @(negedge clk);
        rx_valid[0] = 1'b0; cpu_wen = 1'b0; cpu_waddr = 16'h0000;
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0817) begin
            n_bad++;
            $display("FAIL clr_vs_ovf: got %h want 0817", d);
        end
        wr(16'hFF03, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            rd(16'hFF00, d, h);
            n_cmp++;
            if (d !== 16'h0010 + 16'(i)) begin
                n_bad++;
                $display("FAIL rx_wrap[%0d]: got %h want %h", i, d, 16'h0010 + 16'(i));
            end
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_bad++;
            $display("FAIL rx_after_wrap: got %h want 0004", d);
        end
    endtask

    task automatic test_tx();
        logic [15:0] d;
        logic        h;
        tx_ready = 2'b00;
        wr(16'hFF04, 16'h0041);
        wr(16'hFF04, 16'h0042);
        n_cmp++;
        if ({tx_valid[1], tx_data[31:16]} !== {1'b1, 16'h0041}) begin
            n_bad++;
            $display("FAIL tx_head: got v=%b %h want v=1 0041", tx_valid[1], tx_data[31:16]);
        end
        rd(16'hFF07, d, h);
        n_cmp++;
        if (d !== 16'h0002) begin
            n_bad++;
            $display("FAIL tx_count: got %h want 0002", d);
        end
        @(negedge clk);
        tx_ready[1] = 1'b1;
        n_cmp++;
        if (tx_data[31:16] !== 16'h0041) begin
            n_bad++;
            $display("FAIL tx_out1: got %h want 0041", tx_data[31:16]);
        end
        @(negedge clk);
        n_cmp++;
        if ({tx_valid[1], tx_data[31:16]} !== {1'b1, 16'h0042}) begin
            n_bad++;
            $display("FAIL tx_out2: got v=%b %h want v=1 0042", tx_valid[1], tx_data[31:16]);
        end
        @(negedge clk);
        tx_ready[1] = 1'b0;
        n_cmp++;
        if (tx_valid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_drained: got %b want 0", tx_valid[1]);
        end
        rd(16'hFF05, d, h);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_bad++;
            $display("FAIL tx_status_empty: got %h want 0004", d);
        end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        logic        h;
        wr(16'hFF06, 16'h0002);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_delay: got %b want 0", irq);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_txe: got %b want 1", irq);
        end
        rd(16'hFF06, d, h);
        n_cmp++;
        if (d !== 16'h0002) begin
            n_bad++;
            $display("FAIL ctrl_read: got %h want 0002", d);
        end
        wr(16'hFF04, 16'h0099);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_hold: got %b want 1", irq);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_drop: got %b want 0", irq);
        end
        tx_ready[1] = 1'b1;
        @(negedge clk);
        tx_ready[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_rearm: got %b want 1", irq);
        end
        wr(16'hFF06, 16'h0000);
    endtask

    task automatic test_simul();
        logic [15:0] d;
        logic        h;
        @(negedge clk);
        rx_valid[1] = 1'b1; rx_data[31:16] = 16'h0055;
        cpu_ren = 1'b1; cpu_raddr = 16'hFF04;
        @(negedge clk);
        rx_valid[1] = 1'b0; cpu_ren = 1'b0; cpu_raddr = 16'h0000;
        n_cmp++;
        if ({cpu_hit, cpu_rdata} !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL pop_empty_push: got hit=%b %h want hit=1 0000", cpu_hit, cpu_rdata);
        end
        rd(16'hFF05, d, h);
        n_cmp++;
        if (d !== 16'h0105) begin
            n_bad++;
            $display("FAIL simul_status: got %h want 0105", d);
        end
        rd(16'hFF04, d, h);
        n_cmp++;
        if (d !== 16'h0055) begin
            n_bad++;
            $display("FAIL simul_pop: got %h want 0055", d);
        end
    endtask

    task automatic test_tx_full_ovf();
        logic [15:0] d;
        logic        h;
        for (int i = 0; i < 8; i++) begin
            wr(16'hFF00, 16'h0100 + 16'(i));
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0008) begin
            n_bad++;
            $display("FAIL tx_full_status: got %h want 0008", d);
        end
        @(negedge clk);
        cpu_wen = 1'b1; cpu_waddr = 16'hFF00; cpu_wdata = 16'hDEAD;
        tx_ready[0] = 1'b1;
        @(negedge clk);
        cpu_wen = 1'b0; cpu_waddr = 16'h0000; tx_ready[0] = 1'b0;
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0020) begin
            n_bad++;
            $display("FAIL tx_ovf_status: got %h want 0020", d);
        end
        rd(16'hFF03, d, h);
        n_cmp++;
        if (d !== 16'h0007) begin
            n_bad++;
            $display("FAIL tx_ovf_count: got %h want 0007", d);
        end
        n_cmp++;
        if (tx_data[15:0] !== 16'h0101) begin
            n_bad++;
            $display("FAIL tx_ovf_head: got %h want 0101", tx_data[15:0]);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] d;
        logic        h;
        @(negedge clk);
        tx_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_drain: got %b want 1", tx_valid[0]);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_valid, rx_ready} !== {2'b00, 2'b11}) begin
            n_bad++;
            $display("FAIL async_reset: got tv=%b rr=%b want tv=00 rr=11", tx_valid, rx_ready);
        end
        @(negedge clk);
        reset = 1'b0; tx_ready = 2'b00;
        rd(16'hFF03, d, h);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_txcnt: got %h want 0000", d);
        end
        rd(16'hFF01, d, h);
        n_cmp++;
        if (d !== 16'h0004) begin
            n_bad++;
            $display("FAIL reset_status2: got %h want 0004", d);
        end
        rd(16'hFF20, d, h);
        n_cmp++;
        if ({h, d} !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL ch_out_of_range: got hit=%b %h want hit=1 0000", h, d);
        end
    endtask

    initial begin
        test_reset();
        test_rx_pop();
        test_rx_overflow();
        test_tx();
        test_irq();
        test_simul();
        test_tx_full_ovf();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
